// File: rtl/multicycle_ctrl.sv
// Multicycle processor controller: sequences fetch/decode/execute/writeback with a memory
// ready handshake, fetch wait, halt and illegal-opcode detection. MC_CTRL_PERF_EN adds a retire counter.
module multicycle_ctrl #(
  parameter int WIDTH      = 16,
  parameter int FETCH_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opCode,
  input  logic [3:0]       opCodeExt,
  input  logic [WIDTH-1:0] conCodesOut,
  input  logic             memReady,
  input  logic             halt,
  output logic [28:0]      ctrlWord,
  output logic             busy,
  output logic             illegalOp,
  output logic             instrRetired,
  output logic [31:0]      retireCount
);

  localparam logic [4:0] S_RESET_PC = 5'd0,  S_FETCH  = 5'd1,  S_WAIT   = 5'd2,  S_DECODE = 5'd3,
                         S_RALU     = 5'd4,  S_IALU   = 5'd5,  S_MOV    = 5'd6,  S_SCOND  = 5'd7,
                         S_LSH      = 5'd8,  S_LSHI   = 5'd9,  S_SAR    = 5'd10, S_LUI    = 5'd11,
                         S_MOVI     = 5'd12, S_WB     = 5'd13, S_LD     = 5'd14, S_LDWB   = 5'd15,
                         S_ST       = 5'd16, S_STDONE = 5'd17, S_SKIP   = 5'd18, S_JC     = 5'd19,
                         S_JCPC     = 5'd20, S_JAL    = 5'd21, S_JALPC  = 5'd22, S_BC     = 5'd23,
                         S_BCPC     = 5'd24, S_HALTED = 5'd25;

  localparam logic [2:0] WAIT_LOAD = (FETCH_WAIT > 0) ? 3'(FETCH_WAIT - 1) : 3'd0;

  typedef struct packed {
    logic       out_reg_en;
    logic       mux_mem_adr;
    logic       mem_data_reg_en;
    logic       reg_file_en;
    logic       instr_reg_en;
    logic       codes_computed;
    logic       mem_write;
    logic       mem_read;
    logic       mux_ext_imm;
    logic       shift_op;
    logic       mux_pc;
    logic       mux_bin;
    logic [1:0] mux_shift_shifter;
    logic [1:0] mux_out;
    logic [1:0] mux_shift_amount;
    logic [1:0] mux_to_reg_file;
    logic [1:0] mux_ain;
    logic [1:0] pc_en;
    logic [4:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic       codes;
    logic [4:0] op;
  } alu_t;

  function automatic logic is_alu(input logic [3:0] code);
    return code inside {4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b0101,
                        4'b0110, 4'b0111, 4'b1001, 4'b1010};
  endfunction

  function automatic alu_t alu_decode(input logic [3:0] code);
    alu_t r;
    r = '0;
    case (code)
      4'b1011: r = '{codes: 1'b1, op: 5'd0};
      4'b0001: r = '{codes: 1'b0, op: 5'd1};
      4'b0010: r = '{codes: 1'b0, op: 5'd2};
      4'b0011: r = '{codes: 1'b0, op: 5'd7};
      4'b0101: r = '{codes: 1'b1, op: 5'd3};
      4'b0110: r = '{codes: 1'b1, op: 5'd4};
      4'b0111: r = '{codes: 1'b1, op: 5'd4};
      4'b1001: r = '{codes: 1'b1, op: 5'd5};
      4'b1010: r = '{codes: 1'b1, op: 5'd6};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] decode_target(input logic [3:0] op, input logic [3:0] ext);
    logic [4:0] t;
    t = S_SKIP;
    case (op)
      4'b0000: if (ext == 4'b1101) t = S_MOV; else if (is_alu(ext)) t = S_RALU;
      4'b0100:
        case (ext)
          4'b0000: t = S_LD;
          4'b0100: t = S_ST;
          4'b1101: t = S_SCOND;
          4'b1100: t = S_JC;
          4'b1000: t = S_JAL;
          default: t = S_SKIP;
        endcase
      4'b1000:
        case (ext)
          4'b0100:          t = S_LSH;
          4'b1000:          t = S_SAR;
          4'b0000, 4'b0001: t = S_LSHI;
          default:          t = S_SKIP;
        endcase
      4'b1100: t = S_BC;
      4'b1111: t = S_LUI;
      4'b1101: t = S_MOVI;
      default: if (is_alu(op)) t = S_IALU;
    endcase
    return t;
  endfunction

  logic [4:0] state, next_state, target;
  logic [2:0] wait_cnt;
  logic       boundary;
  alu_t       alu;
  ctrl_t      cw;
  logic       retire_state;
  logic       cc_unused;

  assign cc_unused = ^conCodesOut;
  assign target    = decode_target(opCode, opCodeExt);
  assign alu       = alu_decode((state == S_RALU) ? opCodeExt : opCode);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_state = state;
    boundary   = 1'b0;
    case (state)
      S_RESET_PC: boundary = 1'b1;
      S_FETCH:    if (memReady) next_state = (FETCH_WAIT == 0) ? S_DECODE : S_WAIT;
      S_WAIT:     if (wait_cnt == 3'd0) next_state = S_DECODE;
      S_DECODE:   next_state = target;
      S_RALU, S_IALU, S_MOV, S_SCOND, S_LSH, S_LSHI, S_SAR, S_LUI, S_MOVI: next_state = S_WB;
      S_LD:       if (memReady) next_state = S_LDWB;
      S_ST:       if (memReady) next_state = S_STDONE;
      S_JC:       next_state = S_JCPC;
      S_JAL:      next_state = S_JALPC;
      S_BC:       next_state = S_BCPC;
      S_WB, S_LDWB, S_STDONE, S_SKIP, S_JCPC, S_JALPC, S_BCPC: boundary = 1'b1;
      S_HALTED:   if (!halt) next_state = S_FETCH;
      default:    next_state = S_RESET_PC;
    endcase
    // Halt is honoured only at an instruction boundary, i.e. on the way into FETCH.
    if (boundary) next_state = halt ? S_HALTED : S_FETCH;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state    <= S_RESET_PC;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH)                       wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != 0)  wait_cnt <= wait_cnt - 3'd1;
    end
  end

  always_comb begin
    cw = '0;
    case (state)
      S_RESET_PC: cw.pc_en = 2'b01;
      S_FETCH:    begin cw.mem_read = 1'b1; cw.instr_reg_en = 1'b1; end
      S_RALU, S_IALU: begin
        cw.alu_op = alu.op; cw.codes_computed = alu.codes;
        cw.mux_ain = 2'd1; cw.mux_bin = 1'b1; cw.mux_out = 2'd1; cw.out_reg_en = 1'b1;
      end
      S_MOV:   begin cw.mux_shift_shifter = 2'd2; cw.mux_shift_amount = 2'd3; cw.out_reg_en = 1'b1; end
      S_SCOND: begin cw.mux_out = 2'd2; cw.out_reg_en = 1'b1; end
      S_LSH:   cw.out_reg_en = 1'b1;
      S_LSHI:  begin cw.mux_shift_amount = 2'd1; cw.mux_ext_imm = 1'b1; cw.out_reg_en = 1'b1; end
      S_SAR:   begin cw.shift_op = 1'b1; cw.out_reg_en = 1'b1; end
      S_LUI:   begin cw.mux_shift_amount = 2'd2; cw.mux_shift_shifter = 2'd1; cw.out_reg_en = 1'b1; end
      S_MOVI, S_BC: begin cw.mux_shift_amount = 2'd3; cw.mux_shift_shifter = 2'd1; cw.out_reg_en = 1'b1; end
      S_WB:    begin cw.mux_to_reg_file = 2'd1; cw.reg_file_en = 1'b1; cw.pc_en = 2'b11; end
      S_LD:    begin cw.mux_mem_adr = 1'b1; cw.mem_read = 1'b1; cw.mem_data_reg_en = 1'b1; end
      S_LDWB:  begin cw.reg_file_en = 1'b1; cw.pc_en = 2'b11; end
      S_ST:    begin cw.mux_mem_adr = 1'b1; cw.mem_write = 1'b1; end
      S_STDONE, S_SKIP: cw.pc_en = 2'b11;
      S_JC, S_JAL: begin
        cw.mux_shift_amount = 2'd3; cw.mux_shift_shifter = 2'd2; cw.out_reg_en = 1'b1;
        if (state == S_JAL) begin cw.mux_to_reg_file = 2'd2; cw.reg_file_en = 1'b1; end
      end
      S_JCPC:  begin cw.mux_pc = conCodesOut[0]; cw.pc_en = 2'b10; end
      S_JALPC: begin cw.mux_pc = 1'b1; cw.pc_en = 2'b10; end
      S_BCPC:  begin cw.mux_pc = conCodesOut[0]; cw.pc_en = 2'b11; end
      default: cw = '0;
    endcase
  end

  assign retire_state = state inside {S_WB, S_LDWB, S_STDONE, S_JCPC, S_JALPC, S_BCPC};

  // All outputs are forced low while reset is held, whatever the state flops contain.
  assign ctrlWord     = reset ? '0 : cw;
  assign busy         = !reset && (state != S_HALTED);
  assign illegalOp    = !reset && (state == S_DECODE) && (target == S_SKIP);
  assign instrRetired = !reset && retire_state;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] retire_cnt;

  always_ff @(posedge clk) begin
    if (reset)             retire_cnt <= '0;
    else if (instrRetired) retire_cnt <= retire_cnt + 32'd1;
  end

  assign retireCount = reset ? '0 : retire_cnt;
`else
  assign retireCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction stream against a per-instruction
// cycle model built from the controller's instruction table.
module tb_multicycle_ctrl;

  localparam int FW = 1;
`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int B_ALU = 0,  B_PC = 5,  B_AIN = 7,  B_TORF = 9,  B_SHAMT = 11, B_OUT = 13;
  localparam int B_SHSH = 15, B_BIN = 17, B_MUXPC = 18, B_SHOP = 19, B_EXT = 20, B_RD = 21;
  localparam int B_WR = 22, B_CC = 23, B_IR = 24, B_RF = 25, B_MDR = 26, B_MADR = 27, B_OREG = 28;

  typedef enum int {K_ILL, K_RALU, K_IALU, K_MOV, K_SCOND, K_LSH, K_LSHI, K_SAR, K_LUI, K_MOVI,
                    K_LD, K_ST, K_JC, K_JAL, K_BC} kind_e;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opCode = '0;
  logic [3:0]  opCodeExt = '0;
  logic [15:0] conCodesOut = '0;
  logic        memReady = 1'b0;
  logic        halt = 1'b0;
  logic [28:0] ctrlWord;
  logic        busy, illegalOp, instrRetired;
  logic [31:0] retireCount;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt = '0;

  logic [7:0] legal [16] = '{8'h0D, 8'h05, 8'h0B, 8'h40, 8'h44, 8'h4D, 8'h4C, 8'h48,
                             8'h84, 8'h88, 8'h80, 8'h81, 8'hC0, 8'hF0, 8'hD0, 8'h3A};

  multicycle_ctrl #(.WIDTH(16), .FETCH_WAIT(FW)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .opCodeExt(opCodeExt),
    .conCodesOut(conCodesOut), .memReady(memReady), .halt(halt), .ctrlWord(ctrlWord),
    .busy(busy), .illegalOp(illegalOp), .instrRetired(instrRetired), .retireCount(retireCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] fld(input int v, input int lsb);
    return 29'(v) << lsb;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int alu_of(input logic [3:0] c);
    case (c)
      4'b1011: return 0;
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0011: return 7;
      4'b0101: return 3;
      4'b0110, 4'b0111: return 4;
      4'b1001: return 5;
      4'b1010: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic int sets_codes(input logic [3:0] c);
    return (c == 4'b1011 || c == 4'b0101 || c == 4'b0110 ||
            c == 4'b0111 || c == 4'b1001 || c == 4'b1010) ? 1 : 0;
  endfunction

  function automatic kind_e classify(input logic [3:0] op, input logic [3:0] ext);
    if (op == 4'b0000) begin
      if (ext == 4'b1101) return K_MOV;
      if (alu_of(ext) >= 0) return K_RALU;
      return K_ILL;
    end
    if (op == 4'b0100) begin
      if (ext == 4'b0000) return K_LD;
      if (ext == 4'b0100) return K_ST;
      if (ext == 4'b1101) return K_SCOND;
      if (ext == 4'b1100) return K_JC;
      if (ext == 4'b1000) return K_JAL;
      return K_ILL;
    end
    if (op == 4'b1000) begin
      if (ext == 4'b0100) return K_LSH;
      if (ext == 4'b1000) return K_SAR;
      if (ext[3:1] == 3'b000) return K_LSHI;
      return K_ILL;
    end
    if (op == 4'b1100) return K_BC;
    if (op == 4'b1111) return K_LUI;
    if (op == 4'b1101) return K_MOVI;
    if (alu_of(op) >= 0) return K_IALU;
    return K_ILL;
  endfunction

  // One clock cycle: drive inputs on the falling edge, compare just after it.
  task automatic step(input string tag, input logic [28:0] cw, input logic bsy, input logic ill,
                      input logic ret, input logic rdy, input logic hlt);
    @(negedge clk);
    reset = 1'b0; memReady = rdy; halt = hlt;
    #1;
    check(tag, {busy, illegalOp, instrRetired, ctrlWord}, {bsy, ill, ret, cw});
    check({tag, "_cnt"}, retireCount, exp_cnt);
    if (ret && PERF) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Last cycle before FETCH; hc>0 holds halt so the controller parks in HALTED for hc cycles.
  task automatic boundary(input string tag, input logic [28:0] cw, input logic ret, input int hc);
    step(tag, cw, 1'b1, 1'b0, ret, rb(), hc > 0);
    for (int i = 1; i <= hc; i++) step("halted", '0, 1'b0, 1'b0, 1'b0, rb(), i < hc);
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; memReady = rb(); halt = rb();
      #1;
      check("reset_out", {busy, illegalOp, instrRetired, ctrlWord}, 32'd0);
      check("reset_cnt", retireCount, 32'd0);
    end
    exp_cnt = '0;
  endtask

  task automatic fetch_decode(input int fd, input logic ill);
    logic [28:0] f_cw;
    f_cw = fld(1, B_RD) | fld(1, B_IR);
    for (int i = 0; i < fd; i++) step("fetch", f_cw, 1'b1, 1'b0, 1'b0, 1'b0, rb());
    step("fetch", f_cw, 1'b1, 1'b0, 1'b0, 1'b1, rb());
    for (int i = 0; i < FW; i++) step("wait", '0, 1'b1, 1'b0, 1'b0, rb(), rb());
    step("decode", '0, 1'b1, ill, 1'b0, rb(), rb());
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] ext, input logic [15:0] cc,
                           input int fd, input int md, input int hc);
    kind_e       k;
    logic        eh;
    logic [28:0] oreg, wb_cw, cw;
    logic [3:0]  ac;
    k     = classify(op, ext);
    eh    = (hc > 0) ? 1'b1 : rb();
    oreg  = fld(1, B_OREG);
    wb_cw = fld(1, B_TORF) | fld(1, B_RF) | fld(3, B_PC);
    opCode = op; opCodeExt = ext; conCodesOut = cc;
    fetch_decode(fd, k == K_ILL);
    case (k)
      K_RALU, K_IALU: begin
        ac = (k == K_RALU) ? ext : op;
        cw = fld(alu_of(ac), B_ALU) | fld(sets_codes(ac), B_CC) | fld(1, B_AIN) |
             fld(1, B_BIN) | fld(1, B_OUT) | oreg;
        step("alu", cw, 1'b1, 1'b0, 1'b0, rb(), eh);
        boundary("wb", wb_cw, 1'b1, hc);
      end
      K_MOV, K_SCOND, K_LSH, K_LSHI, K_SAR, K_LUI, K_MOVI: begin
        case (k)
          K_MOV:   cw = fld(2, B_SHSH) | fld(3, B_SHAMT) | oreg;
          K_SCOND: cw = fld(2, B_OUT) | oreg;
          K_LSHI:  cw = fld(1, B_SHAMT) | fld(1, B_EXT) | oreg;
          K_SAR:   cw = fld(1, B_SHOP) | oreg;
          K_LUI:   cw = fld(2, B_SHAMT) | fld(1, B_SHSH) | oreg;
          K_MOVI:  cw = fld(3, B_SHAMT) | fld(1, B_SHSH) | oreg;
          default: cw = oreg;
        endcase
        step("exec", cw, 1'b1, 1'b0, 1'b0, rb(), eh);
        boundary("wb", wb_cw, 1'b1, hc);
      end
      K_LD: begin
        cw = fld(1, B_MADR) | fld(1, B_RD) | fld(1, B_MDR);
        for (int i = 0; i < md; i++) step("ld", cw, 1'b1, 1'b0, 1'b0, 1'b0, eh);
        step("ld", cw, 1'b1, 1'b0, 1'b0, 1'b1, eh);
        boundary("ldwb", fld(1, B_RF) | fld(3, B_PC), 1'b1, hc);
      end
      K_ST: begin
        cw = fld(1, B_MADR) | fld(1, B_WR);
        for (int i = 0; i < md; i++) step("st", cw, 1'b1, 1'b0, 1'b0, 1'b0, eh);
        step("st", cw, 1'b1, 1'b0, 1'b0, 1'b1, eh);
        boundary("stdone", fld(3, B_PC), 1'b1, hc);
      end
      K_JC: begin
        step("jc", fld(3, B_SHAMT) | fld(2, B_SHSH) | oreg, 1'b1, 1'b0, 1'b0, rb(), eh);
        boundary("jcpc", fld(int'(cc[0]), B_MUXPC) | fld(2, B_PC), 1'b1, hc);
      end
      K_JAL: begin
        step("jal", fld(3, B_SHAMT) | fld(2, B_SHSH) | oreg | fld(2, B_TORF) | fld(1, B_RF),
             1'b1, 1'b0, 1'b0, rb(), eh);
        boundary("jalpc", fld(1, B_MUXPC) | fld(2, B_PC), 1'b1, hc);
      end
      K_BC: begin
        step("bc", fld(3, B_SHAMT) | fld(1, B_SHSH) | oreg, 1'b1, 1'b0, 1'b0, rb(), eh);
        boundary("bcpc", fld(int'(cc[0]), B_MUXPC) | fld(3, B_PC), 1'b1, hc);
      end
      default: boundary("skip", fld(3, B_PC), 1'b0, hc);
    endcase
  endtask

  // Store left waiting on memReady, then reset: no completion, straight back to RESET_PC.
  task automatic run_st_abort(input int hold);
    opCode = 4'b0100; opCodeExt = 4'b0100; conCodesOut = 16'($urandom);
    fetch_decode(0, 1'b0);
    for (int i = 0; i < hold; i++)
      step("st_hold", fld(1, B_MADR) | fld(1, B_WR), 1'b1, 1'b0, 1'b0, 1'b0, rb());
    apply_reset(1);
    boundary("reset_pc", fld(1, B_PC), 1'b0, 0);
  endtask

  initial begin
    logic [7:0] pick;
    apply_reset(2);
    boundary("reset_pc", fld(1, B_PC), 1'b0, 0);

    run_instr(4'b0000, 4'b0101, 16'h0000, 0, 0, 0);   // ADD
    run_instr(4'b0100, 4'b0000, 16'h0000, 1, 3, 0);   // LD with 3 wait cycles
    run_instr(4'b0100, 4'b1100, 16'h0001, 0, 0, 0);   // JC taken
    run_instr(4'b0100, 4'b1100, 16'h0000, 0, 0, 0);   // JC not taken
    run_instr(4'b0100, 4'b0011, 16'h0000, 0, 0, 0);   // illegal
    run_instr(4'b0000, 4'b0101, 16'h0000, 0, 0, 2);   // halt during ADD
    run_st_abort(2);

    apply_reset(1);
    boundary("reset_pc", fld(1, B_PC), 1'b0, 0);
    run_instr(4'b0000, 4'b0101, 16'h0000, 0, 0, 0);
    run_instr(4'b0000, 4'b1101, 16'h0000, 0, 0, 0);
    run_instr(4'b0100, 4'b0000, 16'h0000, 0, 1, 0);
    run_instr(4'b0100, 4'b0100, 16'h0000, 0, 1, 0);
    run_instr(4'b0100, 4'b1100, 16'h0001, 0, 0, 1);
    check("cnt5", retireCount, PERF ? 32'd5 : 32'd0);
`ifdef MC_CTRL_PERF_EN
    dut.retire_cnt = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
`endif
    run_instr(4'b1111, 4'b0000, 16'h0000, 0, 0, 1);
    check("wrap", retireCount, 32'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        run_st_abort(int'($urandom_range(1, 3)));
      end else begin
        if ($urandom_range(0, 1) == 1) pick = legal[$urandom_range(0, 15)];
        else                           pick = 8'($urandom);
        run_instr(pick[7:4], pick[3:0], 16'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
